// File: rtl/pc_csr_regs_if.sv
// Bus bundle between pc_csr_regs and its fetch/execute users: PC control,
// PC output and the CSR read/write port.
interface pc_csr_if;
  logic        hold_flag_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic [31:0] pc_o;
  logic [31:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic        we_i;
  logic [31:0] csr_rdata_o;

  modport master (
    output hold_flag_i, jump_flag_i, jump_addr_i, csr_addr_i, csr_wdata_i, we_i,
    input  pc_o, csr_rdata_o
  );

  modport slave (
    input  hold_flag_i, jump_flag_i, jump_addr_i, csr_addr_i, csr_wdata_i, we_i,
    output pc_o, csr_rdata_o
  );
endinterface

// File: rtl/pc_csr_regs.sv
// Program counter plus machine-mode CSR file (combinational read, synchronous write).
// Optional feature macro CSR_COUNTER_EN adds the 64-bit mcycle/cycle counter.
module pc_csr_regs #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE = 32'h4000_0100
) (
  input logic        clk,
  input logic        rst_n,
  pc_csr_if.slave    bus
);
  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
`ifdef CSR_COUNTER_EN
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
`endif

  logic [31:0] pc_q, pc_d;
  logic        mst_mie_q, mst_mie_d;
  logic        mst_mpie_q, mst_mpie_d;
  logic [2:0]  mie_q, mie_d;         // {MEIE, MTIE, MSIE} = bits {11, 7, 3}
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [29:0] mepc_q, mepc_d;       // bits [1:0] are hard-wired zero
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [11:0] addr_s;
  logic [31:0] wdata_s;
  logic [31:0] rdata_s;
  logic        unused_bits_s;

  assign addr_s        = bus.csr_addr_i[11:0];
  assign wdata_s       = bus.csr_wdata_i;
  assign unused_bits_s = ^{bus.csr_addr_i[31:12], bus.jump_addr_i[1:0]};

  // PC next state: jump beats hold, otherwise sequential fetch
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (bus.jump_flag_i) begin
      pc_d = {bus.jump_addr_i[31:2], 2'b00};
    end else if (bus.hold_flag_i) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  // CSR write decode with per-register writable masks
  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (bus.we_i) begin
      case (addr_s)
        ADDR_MSTATUS: begin
          mst_mie_d  = wdata_s[3];
          mst_mpie_d = wdata_s[7];
        end
        ADDR_MIE:      mie_d      = {wdata_s[11], wdata_s[7], wdata_s[3]};
        ADDR_MTVEC:    mtvec_d    = wdata_s;
        ADDR_MSCRATCH: mscratch_d = wdata_s;
        ADDR_MEPC:     mepc_d     = wdata_s[31:2];
        ADDR_MCAUSE:   mcause_d   = wdata_s;
        ADDR_MTVAL:    mtval_d    = wdata_s;
        default:       mtvec_d    = mtvec_q;
      endcase
    end else begin
      mtvec_d = mtvec_q;
    end
  end

  // PC and CSR state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= 3'b000;
      mtvec_q    <= 32'h0000_0000;
      mscratch_q <= 32'h0000_0000;
      mepc_q     <= 30'h0000_0000;
      mcause_q   <= 32'h0000_0000;
      mtval_q    <= 32'h0000_0000;
    end else begin
      pc_q       <= pc_d;
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

`ifdef CSR_COUNTER_EN
  logic [63:0] cycle_q, cycle_d;

  // Cycle counter: a write to either half replaces it and skips that edge's increment
  always_comb begin
    cycle_d = cycle_q + 64'd1;
    if (bus.we_i && (addr_s == ADDR_MCYCLE)) begin
      cycle_d = {cycle_q[63:32], wdata_s};
    end else if (bus.we_i && (addr_s == ADDR_MCYCLEH)) begin
      cycle_d = {wdata_s, cycle_q[31:0]};
    end else begin
      cycle_d = cycle_q + 64'd1;
    end
  end

  // Cycle counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= 64'd0;
    end else begin
      cycle_q <= cycle_d;
    end
  end
`endif

  // Combinational read mux; undecoded addresses read zero
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (addr_s)
      ADDR_MSTATUS:  rdata_s = {19'd0, 2'b11, 3'd0, mst_mpie_q, 3'd0, mst_mie_q, 3'd0};
      ADDR_MISA:     rdata_s = MISA_VALUE;
      ADDR_MIE:      rdata_s = {20'd0, mie_q[2], 3'd0, mie_q[1], 3'd0, mie_q[0], 3'd0};
      ADDR_MTVEC:    rdata_s = mtvec_q;
      ADDR_MSCRATCH: rdata_s = mscratch_q;
      ADDR_MEPC:     rdata_s = {mepc_q, 2'b00};
      ADDR_MCAUSE:   rdata_s = mcause_q;
      ADDR_MTVAL:    rdata_s = mtval_q;
`ifdef CSR_COUNTER_EN
      ADDR_MCYCLE,  ADDR_CYCLE:  rdata_s = cycle_q[31:0];
      ADDR_MCYCLEH, ADDR_CYCLEH: rdata_s = cycle_q[63:32];
`endif
      default:       rdata_s = 32'h0000_0000;
    endcase
  end

  assign bus.pc_o        = pc_q;
  assign bus.csr_rdata_o = rdata_s;
endmodule

// File: tb/tb_pc_csr_regs.sv
// Scoreboard bench for pc_csr_regs: a driver pushes model predictions into a
// queue, a negedge monitor pops them and compares pc_o and csr_rdata_o.
module tb_pc_csr_regs;
  localparam logic [31:0] MISA = 32'h4000_0100;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rd;
    logic [31:0] addr;
  } exp_t;

  logic clk;
  logic rst_n;
  pc_csr_if bus ();

  pc_csr_regs dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        exp_q [$];
  int          n_vec;
  int          n_bad;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_csr [0:4095];
  logic [63:0] m_cnt;

  logic [11:0] addr_tab [0:17] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                   12'h342, 12'h343, 12'h344, 12'h7C0, 12'hB00, 12'hB80,
                                   12'hC00, 12'hC80, 12'h000, 12'hF11, 12'h302, 12'hFFF};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m_mask(input logic [11:0] a);
    case (a)
      12'h300: return 32'h0000_0088;
      12'h304: return 32'h0000_0888;
      12'h305, 12'h340, 12'h342, 12'h343: return 32'hFFFF_FFFF;
      12'h341: return 32'hFFFF_FFFC;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [11:0] a12;
    a12 = a[11:0];
    case (a12)
      12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343: return m_csr[a12];
      12'h301: return MISA;
`ifdef CSR_COUNTER_EN
      12'hB00, 12'hC00: return m_cnt[31:0];
      12'hB80, 12'hC80: return m_cnt[63:32];
`endif
      default: return 32'h0000_0000;
    endcase
  endfunction

  task automatic m_reset();
    m_pc          = 32'h0000_0000;
    m_csr[12'h300] = 32'h0000_1800;
    m_csr[12'h304] = 32'h0;
    m_csr[12'h305] = 32'h0;
    m_csr[12'h340] = 32'h0;
    m_csr[12'h341] = 32'h0;
    m_csr[12'h342] = 32'h0;
    m_csr[12'h343] = 32'h0;
    m_cnt         = 64'd0;
  endtask

  task automatic m_advance(input logic hold, input logic jump, input logic [31:0] jaddr,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic we);
    logic [11:0] a12;
    logic [31:0] mk;
    a12 = addr[11:0];
    mk  = m_mask(a12);
    if (jump) m_pc = jaddr & 32'hFFFF_FFFC;
    else if (!hold) m_pc = m_pc + 32'd4;
    if (we && mk != 32'h0) m_csr[a12] = (m_csr[a12] & ~mk) | (wdata & mk);
`ifdef CSR_COUNTER_EN
    if (we && a12 == 12'hB00) m_cnt[31:0] = wdata;
    else if (we && a12 == 12'hB80) m_cnt[63:32] = wdata;
    else m_cnt = m_cnt + 64'd1;
`endif
  endtask

  // one clock of stimulus; prediction is for the window before the next edge
  task automatic step(input logic rst, input logic hold, input logic jump, input logic [31:0] jaddr,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic we);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n           = rst;
    bus.hold_flag_i = hold;
    bus.jump_flag_i = jump;
    bus.jump_addr_i = jaddr;
    bus.csr_addr_i  = addr;
    bus.csr_wdata_i = wdata;
    bus.we_i        = we;
    if (!rst) m_reset();
    e.pc   = m_pc;
    e.rd   = m_read(addr);
    e.addr = addr;
    exp_q.push_back(e);
    if (rst) m_advance(hold, jump, jaddr, addr, wdata, we);
  endtask

  task automatic rd(input logic [31:0] addr);
    step(1'b1, 1'b0, 1'b0, 32'h0, addr, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
    step(1'b1, 1'b0, 1'b0, 32'h0, addr, wdata, 1'b1);
  endtask

  // monitor: compare the DUT against the oldest prediction mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec = n_vec + 2;
      if (bus.pc_o !== e.pc) begin
        n_bad = n_bad + 1;
        $display("FAIL pc: got %h expected %h", bus.pc_o, e.pc);
      end
      if (bus.csr_rdata_o !== e.rd) begin
        n_bad = n_bad + 1;
        $display("FAIL csr_rdata addr %h: got %h expected %h", e.addr, bus.csr_rdata_o, e.rd);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] ja;
    n_vec = 0;
    n_bad = 0;
    rst_n           = 1'b0;
    bus.hold_flag_i = 1'b0;
    bus.jump_flag_i = 1'b0;
    bus.jump_addr_i = 32'h0;
    bus.csr_addr_i  = 32'h301;
    bus.csr_wdata_i = 32'h0;
    bus.we_i        = 1'b0;
    m_reset();

    // reset with a write pending, then release and free-run
    step(1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h300, 32'hFFFF_FFFF, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h301, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h300, 32'h0, 1'b0);
    rd(32'h301);
    rd(32'h300);
    rd(32'h305);
    rd(32'h341);
    // hold three edges at 0x10
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    rd(32'h0);
    // jump beats hold; low bits cleared
    step(1'b1, 1'b1, 1'b1, 32'h1234_5677, 32'h0, 32'h0, 1'b0);
    rd(32'h0);
    rd(32'h0);
    // wrap at the top of the address space
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0, 32'h0, 1'b0);
    rd(32'h0);
    rd(32'h0);
    // misa is constant
    rd(32'h301);
    wr(32'h301, 32'hFFFF_FFFF);
    rd(32'h301);
    // masked writes, no bypass, ignored upper address bits
    wr(32'h300, 32'hFFFF_FFFF);
    rd(32'h300);
    wr(32'hABCD_E341, 32'hFFFF_FFFF);
    rd(32'h341);
    wr(32'h304, 32'hFFFF_FFFF);
    rd(32'h304);
    wr(32'h344, 32'hFFFF_FFFF);
    rd(32'h344);
    rd(32'h7C0);
    // counter halves
    rd(32'hB00);
    rd(32'hB00);
    wr(32'hB00, 32'h0000_0005);
    rd(32'hB00);
    rd(32'hC00);
    wr(32'hB80, 32'h0000_0007);
    rd(32'hC80);
    rd(32'hB00);

    for (int i = 0; i < 3000; i++) begin
      a  = {$urandom_range(0, 1) == 0 ? 20'h0 : 20'($urandom), addr_tab[$urandom_range(0, 17)]};
      ja = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
           ja, a, 32'($urandom), ($urandom_range(0, 1) == 1));
    end

    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_vec = n_vec + 1;
    if (exp_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_csr_regs.md
# pc_csr_regs

Core front-end state block holding the program counter and the machine-mode CSR file. The PC register feeds instruction fetch and advances by 4, holds, or loads a jump target. The CSR file gives execute a combinational read port and a synchronous write port. Single clock domain; no interrupt or trap logic lives here.

## Interface
- RESET_PC, 32'h0000_0000, PC value while and after reset
- MISA_VALUE, 32'h4000_0100, constant returned for misa (RV32I)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- hold_flag_i  in  1  freeze PC this cycle
- jump_flag_i  in  1  load jump_addr_i into PC
- jump_addr_i  in  32  jump target
- pc_o  out  32  current PC (registered)
- csr_addr_i  in  32  CSR address; only [11:0] decoded, [31:12] ignored
- csr_wdata_i  in  32  CSR write data
- we_i  in  1  1 = write, 0 = read
- csr_rdata_o  out  32  CSR read data (combinational)

## Operation
- PC next-state priority: rst_n low -> RESET_PC; jump_flag_i -> {jump_addr_i[31:2],2'b00}; hold_flag_i -> pc_o; else pc_o + 32'd4.
- Jump beats hold when both high. PC addition wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- CSR map (address: reset value, write behaviour):
  - mstatus 0x300: 0x0000_1800; only bits 3 (MIE) and 7 (MPIE) writable; bits 12:11 (MPP) read 2'b11; others read 0.
  - misa 0x301: MISA_VALUE; writes ignored.
  - mie 0x304: 0; bits 3, 7, 11 writable, others 0.
  - mtvec 0x305: 0; all 32 bits writable.
  - mscratch 0x340: 0; all bits writable.
  - mepc 0x341: 0; bits [1:0] read 0.
  - mcause 0x342, mtval 0x343: 0; all bits writable.
  - mip 0x344: read-only 0.
  - Any other address: reads 0, writes ignored.
- csr_rdata_o = decoded value of csr_addr_i regardless of we_i.
- No write-to-read bypass: a write issued in cycle N becomes visible on csr_rdata_o after that rising edge.

## Timing
- All registers reset asynchronously on rst_n falling; pc_o = RESET_PC and every CSR at its reset value immediately, held until the first rising edge after rst_n rises.
- PC: 1-cycle latency; jump_flag_i sampled at edge N sets pc_o = target after edge N; pc_o increments 4 per edge after that unless held.
- hold_flag_i high for K edges keeps pc_o constant for those K edges.
- CSR write: committed at the rising edge where we_i = 1; one write per cycle.
- CSR read: zero-cycle combinational path from csr_addr_i.
- Reset asserted mid-operation overrides any pending jump, hold, or write.

## Configuration
- CSR_COUNTER_EN defined: 64-bit cycle counter, reset 0, +1 every clock.
  - mcycle 0xB00 / mcycleh 0xB80 are read-write halves; a write to a half replaces that half on that edge, and the counter does not increment that edge.
  - cycle 0xC00 / cycleh 0xC80 are read-only aliases.
- CSR_COUNTER_EN undefined: no counter logic; those four addresses read 0 and ignore writes.

## Test plan
- Reset then free-run: pc_o = 0x0 during reset; after release 0x4, 0x8, 0xC on successive edges.
- Hold high for 3 edges at pc_o = 0x10: pc_o stays 0x10, then 0x14 on the edge after hold drops.
- Jump to 0x1234_5677 with hold also high: pc_o = 0x1234_5674 next edge, then 0x1234_5678.
- Read misa: csr_rdata_o = 0x4000_0100; write 0xFFFF_FFFF to misa, re-read is still 0x4000_0100.
- Write 0xFFFF_FFFF to mstatus: read 0x0000_1800 in the same cycle, 0x0000_1888 after the edge; write 0xFFFF_FFFF to mepc reads back 0xFFFF_FFFC; read address 0x7C0 returns 0.
- With CSR_COUNTER_EN: mcycle reads N then N+1 on consecutive cycles; writing 0x0000_0005 reads 5 the next cycle, then 6. Without the macro: 0xB00 reads 0.
